comp_cond_stage: RTL and testbench

- Registered stage directly downstream of the comp_top comparator.
- Accepts each GT/LT/ET result with a condition code and tag over a valid/ready handshake, and evaluates the condition (EQ, LT, GE, ...).
- Presents taken/flags/tag to the branch/select logic through a 2-entry skid buffer, which decouples comparator timing from consumer back-pressure.
- Keeps a sticky flag-integrity error and a saturating taken counter for debug.

---
 rtl/comp_pkg.sv | 35 +++
 rtl/comp_cond_eval.sv | 43 ++++
 rtl/comp_cond_stage.sv | 175 +++++++++++++++++
 tb/tb_comp_cond_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/comp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : comp_pkg
//  Description : Shared types and constants for the comparator condition
//                stage: condition codes, skid-buffer states, flag indices.
//  Revision    : 1.0 - initial release
// ============================================================================
package comp_pkg;

  // Condition codes carried with each comparator result
  typedef enum logic [2:0] {
    COND_EQ     = 3'b000,
    COND_NE     = 3'b001,
    COND_LT     = 3'b010,
    COND_GE     = 3'b011,
    COND_GT     = 3'b100,
    COND_LE     = 3'b101,
    COND_ALWAYS = 3'b110,
    COND_NEVER  = 3'b111
  } cond_e;

  // Occupancy of the head + skid register pair
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // Bit positions inside the {GT,LT,ET} flag triple
  localparam int FLAG_GT = 2;
  localparam int FLAG_LT = 1;
  localparam int FLAG_ET = 0;

endpackage
`default_nettype wire

// File: rtl/comp_cond_eval.sv
`default_nettype none
// ============================================================================
//  Module      : comp_cond_eval
//  Description : Combinational condition evaluator. Maps a {GT,LT,ET} flag
//                triple and a condition code to a taken bit; a flag triple
//                that is not one-hot never yields taken.
//  Revision    : 1.0 - initial release
// ============================================================================
module comp_cond_eval
  import comp_pkg::*;
(
  input  logic [2:0] flags,
  input  logic [2:0] cond,
  output logic       taken,
  output logic       onehot_ok
);

  logic w_raw;

  // Validate the flag triple and evaluate the condition against it
  always_comb begin
    onehot_ok = 1'b0;
    w_raw     = 1'b0;
    case (flags)
      3'b100, 3'b010, 3'b001: onehot_ok = 1'b1;
      default:                onehot_ok = 1'b0;
    endcase
    case (cond_e'(cond))
      COND_EQ:     w_raw = flags[FLAG_ET];
      COND_NE:     w_raw = ~flags[FLAG_ET];
      COND_LT:     w_raw = flags[FLAG_LT];
      COND_GE:     w_raw = flags[FLAG_GT] | flags[FLAG_ET];
      COND_GT:     w_raw = flags[FLAG_GT];
      COND_LE:     w_raw = flags[FLAG_LT] | flags[FLAG_ET];
      COND_ALWAYS: w_raw = 1'b1;
      COND_NEVER:  w_raw = 1'b0;
      default:     w_raw = 1'b0;
    endcase
    taken = w_raw & onehot_ok;
  end

endmodule
`default_nettype wire

// File: rtl/comp_cond_stage.sv
`default_nettype none
// ============================================================================
//  Module      : comp_cond_stage
//  Description : Registered condition stage behind the comparator. Evaluates
//                the condition at capture, buffers results in a 2-entry
//                head/skid pair, tracks a sticky flag-integrity error and a
//                saturating count of delivered taken results.
//  Revision    : 1.0 - initial release
// ============================================================================
module comp_cond_stage
  import comp_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_gt,
  input  logic             in_lt,
  input  logic             in_et,
  input  logic [2:0]       in_cond,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [2:0]       out_flags,
  output logic [TAG_W-1:0] out_tag,
  output logic             err_onehot,
  input  logic             err_clr,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_head_taken;
  logic [2:0]       r_head_flags;
  logic [TAG_W-1:0] r_head_tag;
  logic             r_skid_taken;
  logic [2:0]       r_skid_flags;
  logic [TAG_W-1:0] r_skid_tag;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  logic [2:0]       w_in_flags;
  logic             w_in_taken;
  logic             w_onehot_ok;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_load_head;
  logic             w_load_skid;
  logic             w_move_skid;

  assign w_in_flags[FLAG_GT] = in_gt;
  assign w_in_flags[FLAG_LT] = in_lt;
  assign w_in_flags[FLAG_ET] = in_et;

  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_xfer = r_out_valid & out_ready;

  comp_cond_eval u_eval (
    .flags     (w_in_flags),
    .cond      (in_cond),
    .taken     (w_in_taken),
    .onehot_ok (w_onehot_ok)
  );

  // Next occupancy and which register loads this cycle
  always_comb begin
    w_state_nxt = r_state;
    w_load_head = 1'b0;
    w_load_skid = 1'b0;
    w_move_skid = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_xfer) begin
          w_load_head = 1'b1;
          w_state_nxt = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_in_xfer && w_out_xfer) begin
          w_load_head = 1'b1;
        end else if (w_in_xfer) begin
          w_load_skid = 1'b1;
          w_state_nxt = ST_FULL;
        end else if (w_out_xfer) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_out_xfer) begin
          w_move_skid = 1'b1;
          w_state_nxt = ST_ONE;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // State register with registered handshake outputs derived from next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != ST_FULL);
      r_out_valid <= (w_state_nxt != ST_EMPTY);
    end
  end

  // Head and skid data registers; head only changes on load or drain-refill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head_taken <= 1'b0;
      r_head_flags <= 3'b000;
      r_head_tag   <= '0;
      r_skid_taken <= 1'b0;
      r_skid_flags <= 3'b000;
      r_skid_tag   <= '0;
    end else begin
      if (w_load_head) begin
        r_head_taken <= w_in_taken;
        r_head_flags <= w_in_flags;
        r_head_tag   <= in_tag;
      end else if (w_move_skid) begin
        r_head_taken <= r_skid_taken;
        r_head_flags <= r_skid_flags;
        r_head_tag   <= r_skid_tag;
      end
      if (w_load_skid) begin
        r_skid_taken <= w_in_taken;
        r_skid_flags <= w_in_flags;
        r_skid_tag   <= in_tag;
      end
    end
  end

  // Sticky integrity error; a new bad accept beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_in_xfer && !w_onehot_ok) begin
      r_err <= 1'b1;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end
  end

  // Saturating count of taken results handed downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_out_xfer && r_head_taken && (r_cnt != c_cnt_max)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_taken  = r_head_taken;
  assign out_flags  = r_head_flags;
  assign out_tag    = r_head_tag;
  assign err_onehot = r_err;
  assign taken_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_comp_cond_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_comp_cond_stage
//  Description : Self-checking bench for comp_cond_stage against a depth-2
//                FIFO reference model with trichotomy-based condition rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_comp_cond_stage;

  localparam int TAG_W   = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_gt = 1'b0;
  logic             in_lt = 1'b0;
  logic             in_et = 1'b0;
  logic [2:0]       in_cond = 3'b000;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             out_taken;
  logic [2:0]       out_flags;
  logic [TAG_W-1:0] out_tag;
  logic             err_onehot;
  logic             err_clr = 1'b0;
  logic [CNT_W-1:0] taken_cnt;

  comp_cond_stage #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_gt      (in_gt),
    .in_lt      (in_lt),
    .in_et      (in_et),
    .in_cond    (in_cond),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_taken  (out_taken),
    .out_flags  (out_flags),
    .out_tag    (out_tag),
    .err_onehot (err_onehot),
    .err_clr    (err_clr),
    .taken_cnt  (taken_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             taken;
    logic [2:0]       flags;
    logic [TAG_W-1:0] tag;
  } ent_t;

  ent_t q[$];
  bit   m_err;
  int   m_cnt;
  int   n_chk;
  int   n_fail;

  // Count one comparison and report it if the values differ
  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, obs, exp, $time);
    end
  endtask

  // Reference condition: derive the ordering relation, then apply the code
  function automatic bit ref_taken(input logic [2:0] f, input logic [2:0] c);
    bit is_gt, is_lt, is_eq;
    if (!(f == 3'b100 || f == 3'b010 || f == 3'b001)) return 1'b0;
    is_gt = (f == 3'b100);
    is_lt = (f == 3'b010);
    is_eq = (f == 3'b001);
    case (c)
      3'd0: return is_eq;
      3'd1: return !is_eq;
      3'd2: return is_lt;
      3'd3: return !is_lt;
      3'd4: return is_gt;
      3'd5: return !is_gt;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit is_onehot(input logic [2:0] f);
    return (f == 3'b100 || f == 3'b010 || f == 3'b001);
  endfunction

  task automatic check_all();
    chk("in_ready", in_ready, (q.size() < 2));
    chk("out_valid", out_valid, (q.size() > 0));
    if (q.size() > 0) begin
      chk("out_taken", out_taken, q[0].taken);
      chk("out_flags", out_flags, q[0].flags);
      chk("out_tag", out_tag, q[0].tag);
    end
    chk("err_onehot", err_onehot, m_err);
    chk("taken_cnt", taken_cnt, m_cnt);
  endtask

  // One clock: drive at negedge, predict transfers, check after the edge
  task automatic cyc(input logic v, input logic [2:0] f, input logic [2:0] c,
                     input logic [TAG_W-1:0] t, input logic ordy, input logic clr);
    bit   ix, ox;
    ent_t e;
    @(negedge clk);
    in_valid  = v;
    {in_gt, in_lt, in_et} = f;
    in_cond   = c;
    in_tag    = t;
    out_ready = ordy;
    err_clr   = clr;
    ix = v && (q.size() < 2);
    ox = (q.size() > 0) && ordy;
    e.taken = ref_taken(f, c);
    e.flags = f;
    e.tag   = t;
    @(posedge clk);
    #1;
    if (ox) begin
      if (q[0].taken && m_cnt < CNT_MAX) m_cnt++;
      void'(q.pop_front());
    end
    if (ix) q.push_back(e);
    if (ix && !is_onehot(f)) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    check_all();
  endtask

  task automatic model_clear();
    q.delete();
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  task automatic check_reset_outputs(input string where);
    chk({where, "_out_valid"}, out_valid, 0);
    chk({where, "_in_ready"}, in_ready, 1);
    chk({where, "_out_taken"}, out_taken, 0);
    chk({where, "_out_flags"}, out_flags, 0);
    chk({where, "_out_tag"}, out_tag, 0);
    chk({where, "_err"}, err_onehot, 0);
    chk({where, "_cnt"}, taken_cnt, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    #1;
    model_clear();
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    model_clear();

    do_reset();

    // Single GT result, tag 3
    cyc(1, 3'b100, 3'd4, 4'd3, 1, 0);
    chk("single_taken", out_taken, 1);
    chk("single_tag", out_tag, 3);
    cyc(0, 3'b000, 3'd0, 4'd0, 1, 0);
    chk("single_cnt", taken_cnt, 1);

    // Every condition against every legal flag triple, streamed
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 3; k++) begin
        cyc(1, 3'(1 << k), 3'(c), 4'(c * 3 + k), 1, 0);
      end
    end
    cyc(0, 3'b000, 3'd0, 4'd0, 1, 0);

    // Back-pressure: fill both entries, attempt a third, then drain
    cyc(1, 3'b001, 3'd0, 4'd1, 0, 0);
    cyc(1, 3'b010, 3'd2, 4'd2, 0, 0);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_head_tag", out_tag, 1);
    cyc(1, 3'b100, 3'd4, 4'd7, 0, 0);
    cyc(0, 3'b000, 3'd0, 4'd0, 1, 0);
    chk("bp_drain1_tag", out_tag, 2);
    cyc(0, 3'b000, 3'd0, 4'd0, 1, 0);
    chk("bp_drained_ready", in_ready, 1);

    // Bad flags, clear racing a bad accept, then a clean clear
    cyc(1, 3'b110, 3'd6, 4'd5, 1, 0);
    chk("bad_taken", out_taken, 0);
    chk("bad_flags", out_flags, 3'b110);
    chk("bad_err", err_onehot, 1);
    cyc(1, 3'b000, 3'd6, 4'd6, 1, 1);
    chk("bad_clr_race", err_onehot, 1);
    cyc(0, 3'b000, 3'd0, 4'd0, 1, 1);
    chk("bad_clr", err_onehot, 0);
    cyc(0, 3'b000, 3'd0, 4'd0, 1, 0);

    // Saturation: five taken results with a 2-bit counter
    do_reset();
    for (int j = 0; j < 6; j++) begin
      cyc((j < 5), 3'b100, 3'd4, 4'(j), 1, 0);
      if (j >= 1) chk("sat_cnt", taken_cnt, (j < 3) ? j : 3);
    end

    // Asynchronous reset while FULL with a sticky error pending
    cyc(1, 3'b110, 3'd6, 4'd9, 0, 0);
    cyc(1, 3'b100, 3'd4, 4'd10, 0, 0);
    chk("full_before_rst", in_ready, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_reset_outputs("async");
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 3; j++) cyc(0, 3'b100, 3'd4, 4'd10, 1, 0);

    // Randomized traffic against the reference model
    for (int j = 0; j < 400; j++) begin
      cyc(1'($urandom_range(0, 3) != 0), 3'($urandom), 3'($urandom),
          4'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
